// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: opcodes, state encoding and
// the default datapath width.
package counter_ctrl_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_e;

endpackage

// File: rtl/updown_counter.sv
// Loadable up/down counter that wraps modulo 2^WIDTH; load wins over enable.
module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = dir ? (q_q + ONE) : (q_q - ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/counter_ctrl.sv
// Command sequencer for an up/down counter: start/stop/pause/resume over a
// valid/ready handshake, one-shot or auto-reload, registered terminal-count strobe.
//
// state  | meaning
// IDLE   | stopped, count holds last value
// LOAD   | one cycle, counter takes init, commands back-pressured
// RUN    | counting toward limit
// PAUSED | count frozen until RESUME/STOP/START
// DONE   | one-shot finished, count holds limit
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_init,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_dir,
  input  logic             cmd_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] init_q, init_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  logic             tc_q, tc_d;

  logic ctr_load, ctr_en;
  logic accept, is_start, is_stop, is_pause, is_resume;
  logic at_limit;

  assign cmd_ready = (state_q != ST_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign is_start  = accept && (cmd_op == OP_START);
  assign is_stop   = accept && (cmd_op == OP_STOP);
  assign is_pause  = accept && (cmd_op == OP_PAUSE);
  assign is_resume = accept && (cmd_op == OP_RESUME);
  assign at_limit  = (count == limit_q);

  always_comb begin
    state_d  = state_q;
    init_d   = init_q;
    limit_d  = limit_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;

    if (is_start) begin
      init_d   = cmd_init;
      limit_d  = cmd_limit;
      dir_d    = cmd_dir;
      reload_d = cmd_reload;
    end

    case (state_q)
      ST_IDLE: begin
        if (is_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ctr_load = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // An accepted STOP/PAUSE/START pre-empts both the step and the compare.
        if (is_stop)       state_d = ST_IDLE;
        else if (is_pause) state_d = ST_PAUSED;
        else if (is_start) state_d = ST_LOAD;
        else if (at_limit) begin
          tc_d = 1'b1;
          if (reload_q) ctr_load = 1'b1;
          else          state_d  = ST_DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (is_resume)     state_d = ST_RUN;
        else if (is_stop)  state_d = ST_IDLE;
        else if (is_start) state_d = ST_LOAD;
      end
      ST_DONE: begin
        if (is_start)     state_d = ST_LOAD;
        else if (is_stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      init_q   <= '0;
      limit_q  <= '0;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      limit_q  <= limit_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  updown_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (init_q),
    .en       (ctr_en),
    .dir      (dir_q),
    .q        (count)
  );

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done     = (state_q == ST_DONE);
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: stimulus pushes hand-computed expected
// outputs tagged with a cycle number; a negedge monitor pops and compares.
module tb_counter_ctrl;

  localparam int ST = 0, SP = 1, PA = 2, RE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_init = 4'd0;
  logic [3:0] cmd_limit = 4'd0;
  logic       cmd_dir = 1'b0;
  logic       cmd_reload = 1'b0;
  logic [3:0] count;
  logic       busy, done, tc_pulse;

  counter_ctrl #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_init   (cmd_init),
    .cmd_limit  (cmd_limit),
    .cmd_dir    (cmd_dir),
    .cmd_reload (cmd_reload),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .tc_pulse   (tc_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    cnt;
    int    busy;
    int    done;
    int    tc;
    int    rdy;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc < cyc_cnt) begin
          chk({e.tag, ".stale"}, e.cyc, cyc_cnt);
        end else begin
          chk({e.tag, ".count"}, int'(count), e.cnt);
          chk({e.tag, ".busy"}, int'(busy), e.busy);
          chk({e.tag, ".done"}, int'(done), e.done);
          chk({e.tag, ".tc_pulse"}, int'(tc_pulse), e.tc);
          chk({e.tag, ".cmd_ready"}, int'(cmd_ready), e.rdy);
        end
      end
    end
  end

  // Drive one cycle's inputs and queue the outputs expected after the next edge.
  task automatic drive(int v, int op, int ini, int lim, int d, int r,
                       int ec, int eb, int ed, int et, int er, string tag);
    exp_t e;
    cmd_valid  = v[0];
    cmd_op     = 2'(op);
    cmd_init   = 4'(ini);
    cmd_limit  = 4'(lim);
    cmd_dir    = d[0];
    cmd_reload = r[0];
    e.cyc = cyc_cnt + 1;
    e.cnt = ec; e.busy = eb; e.done = ed; e.tc = et; e.rdy = er; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic cmd(int op, int ec, int eb, int ed, int et, int er, string tag);
    drive(1, op, 0, 0, 0, 0, ec, eb, ed, et, er, tag);
  endtask

  task automatic start(int ini, int lim, int d, int r, int ec, string tag);
    drive(1, ST, ini, lim, d, r, ec, 1, 0, 0, 0, tag);
  endtask

  task automatic idle(int ec, int eb, int ed, int et, int er, string tag);
    drive(0, 0, 0, 0, 0, 0, ec, eb, ed, et, er, tag);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, ".count"}, int'(count), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".tc_pulse"}, int'(tc_pulse), 0);
    chk({tag, ".cmd_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // one-shot up 3 -> 7
    start(3, 7, 1, 0, 0, "up.load");
    idle(3, 1, 0, 0, 1, "up.c3");
    idle(4, 1, 0, 0, 1, "up.c4");
    idle(5, 1, 0, 0, 1, "up.c5");
    idle(6, 1, 0, 0, 1, "up.c6");
    idle(7, 1, 0, 0, 1, "up.c7");
    idle(7, 0, 1, 1, 1, "up.tc");
    idle(7, 0, 1, 0, 1, "up.hold");

    // one-shot down with wrap 1 -> 14
    start(1, 14, 0, 0, 7, "dn.load");
    idle(1, 1, 0, 0, 1, "dn.c1");
    idle(0, 1, 0, 0, 1, "dn.c0");
    idle(15, 1, 0, 0, 1, "dn.c15");
    idle(14, 1, 0, 0, 1, "dn.c14");
    idle(14, 0, 1, 1, 1, "dn.tc");
    cmd(PA, 14, 0, 1, 0, 1, "dn.pause_ign");

    // auto-reload 0..2
    start(0, 2, 1, 1, 14, "ar.load");
    idle(0, 1, 0, 0, 1, "ar.c0");
    idle(1, 1, 0, 0, 1, "ar.c1");
    idle(2, 1, 0, 0, 1, "ar.c2");
    idle(0, 1, 0, 1, 1, "ar.tc1");
    idle(1, 1, 0, 0, 1, "ar.c1b");
    idle(2, 1, 0, 0, 1, "ar.c2b");
    idle(0, 1, 0, 1, 1, "ar.tc2");
    idle(1, 1, 0, 0, 1, "ar.c1c");
    cmd(SP, 1, 0, 0, 0, 1, "ar.stop");
    idle(1, 0, 0, 0, 1, "ar.idle");

    // pause / resume
    start(0, 15, 1, 0, 1, "pr.load");
    idle(0, 1, 0, 0, 1, "pr.c0");
    idle(1, 1, 0, 0, 1, "pr.c1");
    idle(2, 1, 0, 0, 1, "pr.c2");
    idle(3, 1, 0, 0, 1, "pr.c3");
    idle(4, 1, 0, 0, 1, "pr.c4");
    idle(5, 1, 0, 0, 1, "pr.c5");
    cmd(PA, 5, 1, 0, 0, 1, "pr.pause");
    idle(5, 1, 0, 0, 1, "pr.frz1");
    cmd(PA, 5, 1, 0, 0, 1, "pr.frz2");
    idle(5, 1, 0, 0, 1, "pr.frz3");
    cmd(RE, 5, 1, 0, 0, 1, "pr.resume");
    idle(6, 1, 0, 0, 1, "pr.c6");
    idle(7, 1, 0, 0, 1, "pr.c7");
    cmd(SP, 7, 0, 0, 0, 1, "pr.stop");
    cmd(PA, 7, 0, 0, 0, 1, "pr.idle_pause");
    cmd(RE, 7, 0, 0, 0, 1, "pr.idle_resume");

    // STOP in the terminal-count cycle, RESUME in RUN
    start(2, 4, 1, 0, 7, "co.load");
    idle(2, 1, 0, 0, 1, "co.c2");
    cmd(RE, 3, 1, 0, 0, 1, "co.run_resume");
    idle(4, 1, 0, 0, 1, "co.c4");
    cmd(SP, 4, 0, 0, 0, 1, "co.stop_tc");
    idle(4, 0, 0, 0, 1, "co.no_tc");

    // START while running restarts with new config
    start(8, 12, 1, 0, 4, "rs.load1");
    idle(8, 1, 0, 0, 1, "rs.c8");
    idle(9, 1, 0, 0, 1, "rs.c9");
    start(0, 1, 1, 0, 9, "rs.load2");
    idle(0, 1, 0, 0, 1, "rs.c0");
    idle(1, 1, 0, 0, 1, "rs.c1");
    idle(1, 0, 1, 1, 1, "rs.tc");

    // init == limit with reload: tc every cycle
    start(5, 5, 1, 1, 1, "eq.load");
    idle(5, 1, 0, 0, 1, "eq.c5");
    idle(5, 1, 0, 1, 1, "eq.tc1");
    idle(5, 1, 0, 1, 1, "eq.tc2");
    cmd(SP, 5, 0, 0, 0, 1, "eq.stop");

    // asynchronous reset mid-run, then first command right after release
    start(9, 15, 1, 0, 5, "rr.load");
    idle(9, 1, 0, 0, 1, "rr.c9");
    idle(10, 1, 0, 0, 1, "rr.c10");
    #5;
    rst = 1'b1;
    #1;
    check_reset_outputs("rr.async");
    @(posedge clk);
    #2;
    rst = 1'b0;
    start(3, 3, 1, 0, 0, "rr.load2");
    idle(3, 1, 0, 0, 1, "rr.c3");
    idle(3, 0, 1, 1, 1, "rr.tc");

    repeat (2) @(posedge clk);
    #1;
    chk("sb.drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
